// File: rtl/hqm_aw_multi_lifo_control_pkg.sv
// Shared types and helpers for the multi-stack LIFO controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hqm_aw_multi_lifo_control_pkg;

    // What the controller does with memory for one accepted command.
    typedef enum logic [1:0] {
        HQM_AW_MLIFO_NOOP,
        HQM_AW_MLIFO_PUSH,
        HQM_AW_MLIFO_POP,
        HQM_AW_MLIFO_BYPASS
    } aw_mlifo_cmd_t;

    // floor(log2(v)), 0 for v <= 1. Used as aw_logb2(N-1)+1 to size a field holding 0..N-1.
    function automatic int aw_logb2(input int v);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if ((v >> i) != 0) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/hqm_aw_multi_lifo_control_state.sv
// Per-stack size and flag array; returns the selected stack's size/flags combinationally.
// Latency: updates land one cycle after do_push/do_pop.
// Backpressure: none; guards (do_push/do_pop) are computed by the caller.
// Ports: clk, rst_n, id, do_push, do_pop, cfg_high_wm in; cur_size/cur_full/cur_empty,
//        full/afull/empty vectors and packed status_size out.
module hqm_aw_multi_lifo_control_state
    import hqm_aw_multi_lifo_control_pkg::*;
#(
    parameter int NUM_LIFO  = 4,
    parameter int DEPTH     = 8,
    parameter int IDB2      = 2,
    parameter int DEPTHB2P1 = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IDB2-1:0]               id,
    input  logic                          do_push,
    input  logic                          do_pop,
    input  logic [DEPTHB2P1-1:0]          cfg_high_wm,
    output logic [DEPTHB2P1-1:0]          cur_size,
    output logic                          cur_full,
    output logic                          cur_empty,
    output logic [NUM_LIFO-1:0]           full,
    output logic [NUM_LIFO-1:0]           afull,
    output logic [NUM_LIFO-1:0]           empty,
    output logic [NUM_LIFO*DEPTHB2P1-1:0] status_size
);

    logic [DEPTHB2P1-1:0] size_q [NUM_LIFO];
    logic [DEPTHB2P1-1:0] size_nxt;
    logic [IDB2-1:0]      sel;

    // Out-of-range ids never update state; clamp the read index so it stays in bounds.
    assign sel       = (32'(id) < NUM_LIFO) ? id : '0;
    assign cur_size  = size_q[sel];
    assign cur_full  = full[sel];
    assign cur_empty = empty[sel];

    // Push+pop together (bypass) leaves the size where it was.
    always_comb begin
        size_nxt = cur_size;
        if (do_push && !do_pop) size_nxt = cur_size + DEPTHB2P1'(1);
        else if (do_pop && !do_push) size_nxt = cur_size - DEPTHB2P1'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LIFO; i++) size_q[i] <= '0;
            empty <= '1;
            full  <= '0;
            afull <= '0;
        end else if (do_push || do_pop) begin
            size_q[sel] <= size_nxt;
            empty[sel]  <= (size_nxt == '0);
            full[sel]   <= (size_nxt == DEPTHB2P1'(DEPTH));
            afull[sel]  <= (size_nxt >= cfg_high_wm);
        end
    end

    for (genvar g = 0; g < NUM_LIFO; g++) begin : g_size
        assign status_size[g*DEPTHB2P1 +: DEPTHB2P1] = size_q[g];
    end

endmodule

// File: rtl/hqm_aw_multi_lifo_control.sv
// NUM_LIFO LIFO stacks sharing one single-port RAM, addressed {lifo id, stack pointer}.
// Latency: pop data valid exactly one cycle after the pop command (memory or bypass).
// Backpressure: none; every command is accepted, illegal halves are dropped with an error pulse.
// Ports: cmd (lifo_cmd_v/id/push/push_data/pop), pop result (lifo_pop_v/id/data), per-stack
//        flags and sizes, status_idle, RAM side (mem_re/we/addr/wdata/rdata), error pulses.
// Optional: HQM_AW_MULTI_LIFO_PARITY_EN appends even parity to each RAM word and checks it on pop.
module hqm_aw_multi_lifo_control
    import hqm_aw_multi_lifo_control_pkg::*;
#(
    parameter int NUM_LIFO  = 4,
    parameter int DEPTH     = 8,
    parameter int DWIDTH    = 16,
    parameter int IDB2      = aw_logb2(NUM_LIFO - 1) + 1,
    parameter int DEPTHB2   = aw_logb2(DEPTH - 1) + 1,
    parameter int DEPTHB2P1 = DEPTHB2 + 1,
`ifdef HQM_AW_MULTI_LIFO_PARITY_EN
    parameter int MEMW      = DWIDTH + 1
`else
    parameter int MEMW      = DWIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DEPTHB2P1-1:0]          cfg_high_wm,
    input  logic                          lifo_cmd_v,
    input  logic [IDB2-1:0]               lifo_cmd_id,
    input  logic                          lifo_push,
    input  logic [DWIDTH-1:0]             lifo_push_data,
    input  logic                          lifo_pop,
    output logic                          lifo_pop_v,
    output logic [IDB2-1:0]               lifo_pop_id,
    output logic [DWIDTH-1:0]             lifo_pop_data,
    output logic [NUM_LIFO-1:0]           lifo_full,
    output logic [NUM_LIFO-1:0]           lifo_afull,
    output logic [NUM_LIFO-1:0]           lifo_empty,
    output logic [NUM_LIFO*DEPTHB2P1-1:0] status_size,
    output logic                          status_idle,
    output logic                          mem_re,
    output logic                          mem_we,
    output logic [IDB2+DEPTHB2-1:0]       mem_addr,
    output logic [MEMW-1:0]               mem_wdata,
    input  logic [MEMW-1:0]               mem_rdata,
    output logic                          error_of,
    output logic                          error_uf,
    output logic                          error_id,
    output logic                          error_par
);

    logic [DEPTHB2P1-1:0] cur_size;
    logic [DEPTHB2P1-1:0] size_m1;
    logic                 cur_full;
    logic                 cur_empty;
    logic                 id_ok;
    logic                 cmd_ok;
    logic                 do_push;
    logic                 do_pop;
    aw_mlifo_cmd_t        cmd;

    logic                 pop_v_q;
    logic [IDB2-1:0]      pop_id_q;
    logic                 byp_q;
    logic [DWIDTH-1:0]    byp_data_q;

    assign id_ok     = (32'(lifo_cmd_id) < NUM_LIFO);
    assign cmd_ok    = lifo_cmd_v && id_ok;
    assign do_pop    = cmd_ok && lifo_pop && !cur_empty;
    // A pop in the same cycle frees a slot, so a full stack still accepts push+pop.
    assign do_push   = cmd_ok && lifo_push && (!cur_full || do_pop);
    assign size_m1   = cur_size - DEPTHB2P1'(1);

    always_comb begin
        cmd = HQM_AW_MLIFO_NOOP;
        if (do_push && do_pop)  cmd = HQM_AW_MLIFO_BYPASS;
        else if (do_push)       cmd = HQM_AW_MLIFO_PUSH;
        else if (do_pop)        cmd = HQM_AW_MLIFO_POP;
    end

    assign mem_we   = (cmd == HQM_AW_MLIFO_PUSH);
    assign mem_re   = (cmd == HQM_AW_MLIFO_POP);
    assign mem_addr = {lifo_cmd_id, (cmd == HQM_AW_MLIFO_POP) ? size_m1[DEPTHB2-1:0]
                                                             : cur_size[DEPTHB2-1:0]};
`ifdef HQM_AW_MULTI_LIFO_PARITY_EN
    assign mem_wdata = {^lifo_push_data, lifo_push_data};
    // Stored word XORs to zero when intact; bypassed data never went through the RAM.
    assign error_par = pop_v_q && !byp_q && (^mem_rdata);
`else
    assign mem_wdata = lifo_push_data;
    assign error_par = 1'b0;
`endif

    hqm_aw_multi_lifo_control_state #(
        .NUM_LIFO  (NUM_LIFO),
        .DEPTH     (DEPTH),
        .IDB2      (IDB2),
        .DEPTHB2P1 (DEPTHB2P1)
    ) u_state (
        .clk         (clk),
        .rst_n       (rst_n),
        .id          (lifo_cmd_id),
        .do_push     (do_push),
        .do_pop      (do_pop),
        .cfg_high_wm (cfg_high_wm),
        .cur_size    (cur_size),
        .cur_full    (cur_full),
        .cur_empty   (cur_empty),
        .full        (lifo_full),
        .afull       (lifo_afull),
        .empty       (lifo_empty),
        .status_size (status_size)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_v_q    <= 1'b0;
            pop_id_q   <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            error_of   <= 1'b0;
            error_uf   <= 1'b0;
            error_id   <= 1'b0;
        end else begin
            pop_v_q  <= do_pop;
            pop_id_q <= lifo_cmd_id;
            byp_q    <= (cmd == HQM_AW_MLIFO_BYPASS);
            if (cmd == HQM_AW_MLIFO_BYPASS) byp_data_q <= lifo_push_data;
            error_of <= cmd_ok && lifo_push && !do_push;
            error_uf <= cmd_ok && lifo_pop && cur_empty;
            error_id <= lifo_cmd_v && !id_ok;
        end
    end

    // RAM read data arrives the cycle after mem_re, aligned with pop_v_q.
    assign lifo_pop_v    = pop_v_q;
    assign lifo_pop_id   = pop_id_q;
    assign lifo_pop_data = !pop_v_q ? '0 : (byp_q ? byp_data_q : mem_rdata[DWIDTH-1:0]);
    assign status_idle   = !pop_v_q;

endmodule

// File: tb/tb_hqm_aw_multi_lifo_control.sv
module tb_hqm_aw_multi_lifo_control;
    localparam int NL = 4;
    localparam int D  = 8;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int SW = 4;
`ifdef HQM_AW_MULTI_LIFO_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    logic clk, rst_n;
    logic [SW-1:0] cfg_high_wm;
    logic lifo_cmd_v, lifo_push, lifo_pop;
    logic [IW-1:0] lifo_cmd_id;
    logic [DW-1:0] lifo_push_data;

    logic lifo_pop_v, status_idle, mem_re, mem_we;
    logic error_of, error_uf, error_id, error_par;
    logic [IW-1:0] lifo_pop_id;
    logic [DW-1:0] lifo_pop_data;
    logic [NL-1:0] lifo_full, lifo_afull, lifo_empty;
    logic [NL*SW-1:0] status_size;
    logic [IW+2:0] mem_addr;
    logic [MW-1:0] mem_wdata, mem_rdata;

    // Second instance with three stacks, used to see an out-of-range id rejected.
    logic pop_v3, idle3, re3, we3, of3, uf3, eid3, par3;
    logic [IW-1:0] pop_id3;
    logic [DW-1:0] pop_data3;
    logic [2:0] full3, afull3, empty3;
    logic [3*SW-1:0] size3;
    logic [IW+2:0] addr3;
    logic [MW-1:0] wdata3;
    logic [MW-1:0] rdata3;
    assign rdata3 = '0;

    hqm_aw_multi_lifo_control #(.NUM_LIFO(NL), .DEPTH(D), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_high_wm(cfg_high_wm),
        .lifo_cmd_v(lifo_cmd_v), .lifo_cmd_id(lifo_cmd_id), .lifo_push(lifo_push),
        .lifo_push_data(lifo_push_data), .lifo_pop(lifo_pop),
        .lifo_pop_v(lifo_pop_v), .lifo_pop_id(lifo_pop_id), .lifo_pop_data(lifo_pop_data),
        .lifo_full(lifo_full), .lifo_afull(lifo_afull), .lifo_empty(lifo_empty),
        .status_size(status_size), .status_idle(status_idle),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .error_of(error_of), .error_uf(error_uf), .error_id(error_id), .error_par(error_par)
    );

    hqm_aw_multi_lifo_control #(.NUM_LIFO(3), .DEPTH(D), .DWIDTH(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_high_wm(cfg_high_wm),
        .lifo_cmd_v(lifo_cmd_v), .lifo_cmd_id(lifo_cmd_id), .lifo_push(lifo_push),
        .lifo_push_data(lifo_push_data), .lifo_pop(lifo_pop),
        .lifo_pop_v(pop_v3), .lifo_pop_id(pop_id3), .lifo_pop_data(pop_data3),
        .lifo_full(full3), .lifo_afull(afull3), .lifo_empty(empty3),
        .status_size(size3), .status_idle(idle3),
        .mem_re(re3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3),
        .mem_rdata(rdata3),
        .error_of(of3), .error_uf(uf3), .error_id(eid3), .error_par(par3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one-cycle read latency; flip_mask corrupts read data on demand.
    logic [MW-1:0] ram [0:NL*D-1];
    logic [MW-1:0] rdq;
    logic [MW-1:0] flip_mask;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) rdq <= ram[mem_addr];
    end
    assign mem_rdata = rdq ^ flip_mask;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each stack is a queue; registered outputs expected after the last command.
    logic [DW-1:0] stk [NL][$];
    logic [NL-1:0] exp_afull;
    logic exp_pop_v, exp_of, exp_uf, exp_par, chk_en, par_flip;
    logic [IW-1:0] exp_pop_id;
    logic [DW-1:0] exp_pop_data;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NL*SW-1:0] esz;
            logic [NL-1:0] ef, ee;
            chk("pop_v", 32'(lifo_pop_v), 32'(exp_pop_v));
            if (exp_pop_v) begin
                chk("pop_id", 32'(lifo_pop_id), 32'(exp_pop_id));
                chk("pop_data", 32'(lifo_pop_data), 32'(exp_pop_data));
            end
            chk("error_of", 32'(error_of), 32'(exp_of));
            chk("error_uf", 32'(error_uf), 32'(exp_uf));
            chk("error_id", 32'(error_id), 32'(0));
            chk("error_par", 32'(error_par), 32'(exp_par));
            chk("status_idle", 32'(status_idle), 32'(!exp_pop_v));
            for (int i = 0; i < NL; i++) begin
                esz[i*SW +: SW] = SW'(stk[i].size());
                ef[i] = (stk[i].size() == D);
                ee[i] = (stk[i].size() == 0);
            end
            chk("status_size", 32'(status_size), 32'(esz));
            chk("full", 32'(lifo_full), 32'(ef));
            chk("empty", 32'(lifo_empty), 32'(ee));
            chk("afull", 32'(lifo_afull), 32'(exp_afull));
            exp_pop_v = 1'b0;
            exp_of = 1'b0;
            exp_uf = 1'b0;
            exp_par = 1'b0;
        end
    end

    task automatic do_cmd(input logic [IW-1:0] id, input logic push, input logic [DW-1:0] data,
                          input logic pop);
        int n;
        logic dpush, dpop, we, re;
        @(negedge clk);
        lifo_cmd_v = 1'b1;
        lifo_cmd_id = id;
        lifo_push = push;
        lifo_push_data = data;
        lifo_pop = pop;
        #1;
        n = stk[id].size();
        dpop = pop && (n != 0);
        dpush = push && ((n < D) || dpop);
        we = dpush && !dpop;
        re = dpop && !dpush;
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_re", 32'(mem_re), 32'(re));
        if (we) begin
            chk("wr_addr", 32'(mem_addr), 32'(int'(id) * D + n));
            chk("wr_data", 32'(mem_wdata[DW-1:0]), 32'(data));
`ifdef HQM_AW_MULTI_LIFO_PARITY_EN
            chk("wr_parity", 32'(mem_wdata[DW]), 32'(^data));
`endif
        end
        if (re) chk("rd_addr", 32'(mem_addr), 32'(int'(id) * D + n - 1));
        if (id == 2'd3) begin
            chk("id3_mem_we", 32'(we3), 32'(0));
            chk("id3_mem_re", 32'(re3), 32'(0));
        end
        exp_of = push && !dpush;
        exp_uf = pop && (n == 0);
        if (dpush) stk[id].push_back(data);
        if (dpop) begin
            exp_pop_v = 1'b1;
            exp_pop_id = id;
            exp_pop_data = stk[id].pop_back();
            exp_par = re && par_flip;
        end
        if (dpush || dpop) exp_afull[id] = (stk[id].size() >= int'(cfg_high_wm));
        @(posedge clk);
        #1;
        lifo_cmd_v = 1'b0;
        lifo_push = 1'b0;
        lifo_pop = 1'b0;
    endtask

    // Lands in the cycle where the previous command's registered results are visible.
    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        chk_en = 1'b0;
        par_flip = 1'b0;
        flip_mask = '0;
        cfg_high_wm = SW'(5);
        lifo_cmd_v = 1'b0;
        lifo_cmd_id = '0;
        lifo_push = 1'b0;
        lifo_pop = 1'b0;
        lifo_push_data = '0;
        exp_afull = '0;
        exp_pop_v = 1'b0;
        exp_pop_id = '0;
        exp_pop_data = '0;
        exp_of = 1'b0;
        exp_uf = 1'b0;
        exp_par = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("rst_empty", 32'(lifo_empty), 32'h0000_000F);
        chk("rst_full", 32'(lifo_full), 32'h0);
        chk("rst_afull", 32'(lifo_afull), 32'h0);
        chk("rst_pop_v", 32'(lifo_pop_v), 32'h0);
        chk("rst_idle", 32'(status_idle), 32'h1);
        chk("rst_size", 32'(status_size), 32'h0);
        chk("rst_pop_data", 32'(lifo_pop_data), 32'h0);
        chk("rst_errors", 32'({error_of, error_uf, error_id, error_par}), 32'h0);
        chk_en = 1'b1;

        // Stack 2: three pushes, then pops come back in reverse order.
        do_cmd(2'd2, 1'b1, 16'h0011, 1'b0);
        do_cmd(2'd2, 1'b1, 16'h0022, 1'b0);
        do_cmd(2'd2, 1'b1, 16'h0033, 1'b0);
        settle();
        chk("lit_size_s2", 32'(status_size), 32'h0000_0300);
        do_cmd(2'd2, 1'b0, 16'h0, 1'b1);
        settle();
        chk("lit_pop1", 32'({lifo_pop_v, lifo_pop_id, lifo_pop_data}), 32'h0006_0033);
        do_cmd(2'd2, 1'b0, 16'h0, 1'b1);
        settle();
        chk("lit_pop2", 32'({lifo_pop_v, lifo_pop_id, lifo_pop_data}), 32'h0006_0022);
        do_cmd(2'd2, 1'b0, 16'h0, 1'b1);
        settle();
        chk("lit_pop3", 32'({lifo_pop_v, lifo_pop_id, lifo_pop_data}), 32'h0006_0011);

        // Almost-full threshold 5 on stack 1.
        for (int i = 0; i < 4; i++) do_cmd(2'd1, 1'b1, 16'(16'h0100 + i), 1'b0);
        settle();
        chk("lit_afull_4", 32'(lifo_afull), 32'h0);
        do_cmd(2'd1, 1'b1, 16'h0104, 1'b0);
        settle();
        chk("lit_afull_5", 32'(lifo_afull), 32'h2);

        // Fill stack 0, overflow, then bypass on a full stack.
        for (int i = 0; i < D; i++) do_cmd(2'd0, 1'b1, 16'(16'h0A00 + i), 1'b0);
        settle();
        chk("lit_full", 32'(lifo_full), 32'h1);
        do_cmd(2'd0, 1'b1, 16'h0BAD, 1'b0);
        settle();
        chk("lit_of", 32'({error_of, status_size}), 32'h0001_0058);
        do_cmd(2'd0, 1'b1, 16'h00AA, 1'b1);
        settle();
        chk("lit_bypass", 32'({lifo_pop_v, lifo_pop_data}), 32'h0001_00AA);
        chk("lit_bypass_size", 32'(status_size), 32'h0000_0058);

        // Back-to-back mixed traffic: pop stack 0 then stack 1 in consecutive cycles.
        do_cmd(2'd0, 1'b0, 16'h0, 1'b1);
        do_cmd(2'd1, 1'b0, 16'h0, 1'b1);
        do_cmd(2'd2, 1'b1, 16'h0C0C, 1'b0);

        // Underflow on empty stack 3; the three-stack instance sees an illegal id.
        do_cmd(2'd3, 1'b0, 16'h0, 1'b1);
        settle();
        chk("lit_uf", 32'({error_uf, lifo_pop_v}), 32'h2);
        chk("lit_id3", 32'(eid3), 32'h1);
        // Push+pop on an empty stack: pop rejected, push still happens.
        do_cmd(2'd3, 1'b1, 16'h0D0D, 1'b1);
        settle();
        chk("lit_uf_push", 32'({error_uf, status_size[15:12]}), 32'h11);

`ifdef HQM_AW_MULTI_LIFO_PARITY_EN
        do_cmd(2'd2, 1'b1, 16'h0001, 1'b0);
        par_flip = 1'b1;
        flip_mask = MW'(1) << DW;
        do_cmd(2'd2, 1'b0, 16'h0, 1'b1);
        settle();
        chk("lit_par", 32'({error_par, lifo_pop_v, lifo_pop_data}), 32'h0003_0001);
        par_flip = 1'b0;
        flip_mask = '0;
`endif

        // Reset during a pop cycle drops the pop and clears every stack.
        @(negedge clk);
        lifo_cmd_v = 1'b1;
        lifo_cmd_id = 2'd1;
        lifo_pop = 1'b1;
        #1;
        chk("lit_rst_pop_re", 32'(mem_re), 32'h1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        lifo_cmd_v = 1'b0;
        lifo_pop = 1'b0;
        for (int i = 0; i < NL; i++) stk[i].delete();
        exp_afull = '0;
        exp_pop_v = 1'b0;
        exp_of = 1'b0;
        exp_uf = 1'b0;
        exp_par = 1'b0;
        settle();
        chk("lit_rst_pop_v", 32'(lifo_pop_v), 32'h0);
        chk("lit_rst_size", 32'(status_size), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        do_cmd(2'd1, 1'b1, 16'h0E0E, 1'b0);
        do_cmd(2'd1, 1'b0, 16'h0, 1'b1);
        settle();
        chk("lit_after_rst", 32'({lifo_pop_v, lifo_pop_data}), 32'h0001_0E0E);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
